// File: rtl/flyer_pkg.sv
// Shared definitions for the flying-obstacle pool.
// Holds the per-channel state enum, spawn/park heights, sprite ROM bases,
// LFSR height-selection thresholds and the LFSR seed, plus a helper that
// maps an LFSR sample to a spawn height.
package flyer_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_FLY  = 1'b1
  } fly_state_e;

  localparam logic [9:0]  Y_HIGH       = 10'd210;
  localparam logic [9:0]  Y_MID        = 10'd270;
  localparam logic [9:0]  Y_LOW        = 10'd300;
  localparam logic [9:0]  Y_PARK       = 10'd480;

  localparam logic [17:0] BASE_WING_DN = 18'd171995;
  localparam logic [17:0] BASE_WING_UP = 18'd179355;

  localparam logic [5:0]  LFSR_T0      = 6'd16;
  localparam logic [5:0]  LFSR_T1      = 6'd48;
  localparam logic [5:0]  LFSR_SEED    = 6'b101010;

  function automatic logic [9:0] spawn_height(input logic [5:0] r);
    if (r < LFSR_T0)      return Y_HIGH;
    else if (r < LFSR_T1) return Y_MID;
    else                  return Y_LOW;
  endfunction

endpackage

// File: rtl/lfsr.sv
// Fibonacci LFSR (x^N + x^(N-1) + 1, maximal for N=6) with step enable.
// Ports: clk, reset (sync, active-high, loads SEED), en (advance one step),
// q (current register value).
module lfsr #(
  parameter int            N    = 6,
  parameter logic [N-1:0]  SEED = '1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         en,
  output logic [N-1:0] q
);

  logic [N-1:0] q_q;
  logic [N-1:0] q_d;

  always_comb begin
    q_d = q_q;
    if (en) q_d = {q_q[N-2:0], q_q[N-1] ^ q_q[N-2]};
  end

  always_ff @(posedge clk) begin
    if (reset) q_q <= SEED;
    else       q_q <= q_d;
  end

  assign q = q_q;

endmodule

// File: rtl/draw_flyer_pool.sv
// Pool of NUM_FLYERS flying obstacles: motion, spawning, wing animation and
// per-pixel sprite lookup.
// Ports:
//   Clk, Reset            clock, synchronous active-high reset
//   frame_tick            one-cycle pulse per video frame
//   Game_State, Dead      run gating (00 idle / 10 over / Dead freeze)
//   Speed_up              double speed on the tick it is high
//   WriteX, WriteY        pixel being written
//   Cactus_PosX/SizeX     cactus extent; spawning only while it sits in x 0..320
//   flyer_on_wr           registered: a flyer covers the pixel
//   address               registered sprite ROM address for the pixel
//   flyer_id              registered winning channel index
//   active                per-channel FLY flag (channel FSM state)
module draw_flyer_pool
  import flyer_pkg::*;
#(
  parameter int NUM_FLYERS  = 2,
  parameter int SPR_W       = 92,
  parameter int SPR_H       = 80,
  parameter int ANIM_PERIOD = 10,
  parameter int SPAWN_X     = 980,
  parameter int MIN_GAP     = 60,
  parameter int BASE_SPEED  = 4
) (
  input  logic                   Clk,
  input  logic                   Reset,
  input  logic                   frame_tick,
  input  logic [1:0]             Game_State,
  input  logic                   Dead,
  input  logic                   Speed_up,
  input  logic [9:0]             WriteX,
  input  logic [9:0]             WriteY,
  input  logic signed [10:0]     Cactus_PosX,
  input  logic [9:0]             Cactus_SizeX,
  output logic                   flyer_on_wr,
  output logic [17:0]            address,
  output logic [1:0]             flyer_id,
  output logic [NUM_FLYERS-1:0]  active
);

  localparam logic signed [11:0] SPR_W_S   = 12'(SPR_W);
  localparam logic [10:0]        SPR_H_U   = 11'(SPR_H);
  localparam logic signed [10:0] EXIT_X    = 11'(-SPR_W);
  localparam logic signed [10:0] SPAWN_X_S = 11'(SPAWN_X);
  localparam logic signed [10:0] SPEED_1   = 11'(BASE_SPEED);
  localparam logic signed [10:0] SPEED_2   = 11'(2 * BASE_SPEED);
  localparam logic [15:0]        MIN_GAP_U = 16'(MIN_GAP);
  localparam logic [7:0]         ANIM_U    = 8'(ANIM_PERIOD);

  fly_state_e            state_q [NUM_FLYERS];
  fly_state_e            state_d [NUM_FLYERS];
  logic signed [10:0]    pos_x_q [NUM_FLYERS];
  logic signed [10:0]    pos_x_d [NUM_FLYERS];
  logic [9:0]            pos_y_q [NUM_FLYERS];
  logic [9:0]            pos_y_d [NUM_FLYERS];
  logic [15:0]           gap_q, gap_d;
  logic [7:0]            wing_cnt_q, wing_cnt_d;
  logic                  wing_dn_q, wing_dn_d;
  logic                  flyer_on_wr_q, flyer_on_wr_d;
  logic [17:0]           address_q, address_d;
  logic [1:0]            flyer_id_q, flyer_id_d;

  logic                  running, tick_run, cactus_ok, can_spawn, spawned;
  logic signed [10:0]    speed, nx;
  logic [5:0]            lfsr_val;
  logic signed [11:0]    wx, px;
  logic [17:0]           off_x, off_y;

  assign running  = (Game_State != 2'b00) && (Game_State != 2'b10) && !Dead;
  assign tick_run = frame_tick && running;

  lfsr #(.N(6), .SEED(LFSR_SEED)) u_lfsr (
    .clk   (Clk),
    .reset (Reset),
    .en    (tick_run),
    .q     (lfsr_val)
  );

  // Cactus must start on-screen and end by x=320, i.e. it is well clear of
  // the right edge where flyers enter.
  assign cactus_ok = !Cactus_PosX[10] &&
                     (({1'b0, Cactus_PosX[9:0]} + {1'b0, Cactus_SizeX}) <= 11'd320);
  assign can_spawn = tick_run && (gap_q == 16'd0) && cactus_ok;

  always_comb begin
    state_d    = state_q;
    pos_x_d    = pos_x_q;
    pos_y_d    = pos_y_q;
    gap_d      = gap_q;
    wing_cnt_d = wing_cnt_q;
    wing_dn_d  = wing_dn_q;
    spawned    = 1'b0;
    nx         = '0;
    speed      = Speed_up ? SPEED_2 : SPEED_1;
    if (tick_run) begin
      for (int i = 0; i < NUM_FLYERS; i++) begin
        // Eligibility uses the pre-tick state, so a channel leaving this tick
        // cannot be re-spawned until the next one.
        if (state_q[i] == ST_FLY) begin
          nx = pos_x_q[i] - speed;
          if (nx <= EXIT_X) begin
            state_d[i] = ST_IDLE;
            pos_x_d[i] = SPAWN_X_S;
            pos_y_d[i] = Y_PARK;
          end else begin
            pos_x_d[i] = nx;
          end
        end else if (can_spawn && !spawned) begin
          state_d[i] = ST_FLY;
          pos_x_d[i] = SPAWN_X_S;
          pos_y_d[i] = spawn_height(lfsr_val);
          spawned    = 1'b1;
        end
      end
      if (spawned)              gap_d = MIN_GAP_U;
      else if (gap_q != 16'd0)  gap_d = gap_q - 16'd1;
      if (wing_cnt_q == ANIM_U) begin
        wing_cnt_d = 8'd1;
        wing_dn_d  = ~wing_dn_q;
      end else begin
        wing_cnt_d = wing_cnt_q + 8'd1;
      end
    end
  end

  always_comb begin
    flyer_on_wr_d = 1'b0;
    flyer_id_d    = 2'd0;
    off_x         = '0;
    off_y         = '0;
    px            = '0;
    wx            = $signed({2'b00, WriteX});
    // Scan from the top index down so the lowest hitting index is written last.
    for (int i = NUM_FLYERS - 1; i >= 0; i--) begin
      px = {pos_x_q[i][10], pos_x_q[i]};
      if (state_q[i] == ST_FLY && wx >= px && wx < px + SPR_W_S &&
          {1'b0, WriteY} >= {1'b0, pos_y_q[i]} &&
          {1'b0, WriteY} <  {1'b0, pos_y_q[i]} + SPR_H_U) begin
        flyer_on_wr_d = 1'b1;
        flyer_id_d    = 2'(i);
        off_x         = 18'(wx - px);
        off_y         = 18'(WriteY - pos_y_q[i]);
      end
    end
    address_d = '0;
    if (flyer_on_wr_d)
      address_d = (wing_dn_q ? BASE_WING_DN : BASE_WING_UP) + off_y * 18'(SPR_W) + off_x;
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      for (int i = 0; i < NUM_FLYERS; i++) begin
        state_q[i] <= ST_IDLE;
        pos_x_q[i] <= SPAWN_X_S;
        pos_y_q[i] <= Y_PARK;
      end
      gap_q         <= '0;
      wing_cnt_q    <= 8'd1;
      wing_dn_q     <= 1'b1;
      flyer_on_wr_q <= 1'b0;
      address_q     <= '0;
      flyer_id_q    <= '0;
    end else begin
      for (int i = 0; i < NUM_FLYERS; i++) begin
        state_q[i] <= state_d[i];
        pos_x_q[i] <= pos_x_d[i];
        pos_y_q[i] <= pos_y_d[i];
      end
      gap_q         <= gap_d;
      wing_cnt_q    <= wing_cnt_d;
      wing_dn_q     <= wing_dn_d;
      flyer_on_wr_q <= flyer_on_wr_d;
      address_q     <= address_d;
      flyer_id_q    <= flyer_id_d;
    end
  end

  always_comb begin
    active = '0;
    for (int i = 0; i < NUM_FLYERS; i++) active[i] = (state_q[i] == ST_FLY);
  end

  assign flyer_on_wr = flyer_on_wr_q;
  assign address     = address_q;
  assign flyer_id    = flyer_id_q;

endmodule

// File: doc/draw_flyer_pool.md
DRAW_FLYER_POOL -- requirements
Module: draw_flyer_pool

Interface
REQ-001 SHALL have parameter NUM_FLYERS, default 2: number of independent flying-obstacle channels (1..4).
REQ-002 SHALL have parameter SPR_W, default 92: sprite width in pixels.
REQ-003 SHALL have parameter SPR_H, default 80: sprite height in pixels.
REQ-004 SHALL have parameter ANIM_PERIOD, default 10: frame ticks per wing-frame toggle.
REQ-005 SHALL have parameter SPAWN_X, default 980: PosX loaded on spawn and reset.
REQ-006 SHALL have parameter MIN_GAP, default 60: minimum frame ticks between two spawns.
REQ-007 SHALL have parameter BASE_SPEED, default 4: pixels moved left per frame tick.
REQ-008 Clk  input  1  system clock; one clock domain only.
REQ-009 Reset  input  1  synchronous, active-high reset.
REQ-010 frame_tick  input  1  one-Clk pulse per video frame.
REQ-011 Game_State  input  2  00 = idle, 10 = over, any other value = running.
REQ-012 Dead  input  1  player dead; freezes the block.
REQ-013 Speed_up  input  1  doubles speed when high.
REQ-014 WriteX, WriteY  input  10 each  pixel currently being written.
REQ-015 Cactus_PosX  input  11 signed  cactus left edge.
REQ-016 Cactus_SizeX  input  10  cactus width.
REQ-017 flyer_on_wr  output  1  a flyer covers the registered pixel.
REQ-018 address  output  18  sprite ROM address for that pixel.
REQ-019 flyer_id  output  2  index of the winning channel.
REQ-020 active  output  NUM_FLYERS  per-channel FLY flag.

Function
REQ-021 SHALL treat the block as "running" when Game_State is not 00 or 10 and Dead=0; otherwise frozen: no motion, no spawn, no animation change, no LFSR step.
REQ-022 Each channel SHALL have states IDLE and FLY, plus a signed 11-bit PosX and a 10-bit PosY.
REQ-023 On a running frame_tick, a FLY channel SHALL subtract speed from PosX, where speed = BASE_SPEED, or 2*BASE_SPEED if Speed_up is sampled high on that tick.
REQ-024 A FLY channel SHALL enter IDLE on the tick where updated PosX <= -SPR_W; PosX then = SPAWN_X and PosY = 480.
REQ-025 A spawn SHALL occur on a running frame_tick only if all of the following hold: the gap counter = 0, at least one channel was IDLE before the tick, and Cactus_PosX >= 0 with Cactus_PosX + Cactus_SizeX <= 320.
REQ-026 A spawn SHALL use the lowest-index IDLE channel only; at most one spawn per tick.
REQ-027 A channel that exits on a tick SHALL NOT be eligible to spawn on that same tick.
REQ-028 On spawn, PosY SHALL be set from the LFSR value r: 210 if r < 16, 270 if r < 48, else 300. PosX = SPAWN_X. The gap counter SHALL reload to MIN_GAP and decrement on each running tick, saturating at 0.
REQ-029 A global wing counter SHALL count 1..ANIM_PERIOD on running ticks and toggle wing_dn at the wrap.
REQ-030 A channel SHALL hit when it is in FLY and PosX <= WriteX < PosX+SPR_W and PosY <= WriteY < PosY+SPR_H, using signed compare. This handles partial off-screen on the left.
REQ-031 On multiple hits, the lowest index SHALL win.
REQ-032 address SHALL be base + (WriteY-PosY)*SPR_W + (WriteX-PosX), where base = 171995 if wing_dn, else 179355.
REQ-033 flyer_on_wr, address and flyer_id SHALL be registered with 1-Clk latency from WriteX/WriteY. With no hit: flyer_on_wr=0, address=0, flyer_id=0.

Reset
REQ-034 Reset SHALL override frame_tick in the same cycle.
REQ-035 On Reset, all channels SHALL go to IDLE with PosX=SPAWN_X and PosY=480; gap counter=0; wing counter=1; wing_dn=1; LFSR seed=6'b101010; all outputs 0 on the next edge.
REQ-036 Reset SHALL abort any in-flight channel; no residual pixels SHALL appear after Reset.

Structure
REQ-037 Package flyer_pkg SHALL hold the IDLE/FLY enum, the heights 210/270/300/480, the sprite bases 171995/179355, and the LFSR thresholds 16/48.
REQ-038 SHALL instantiate the existing LFSR #(6), clocked by Clk and enabled by the running frame_tick.

Verification
REQ-039 Reset, running, cactus at 0 width 50, tick -> ch0 enters FLY at PosX=980 with PosY in {210,270,300}; active=01.
REQ-040 Ch0 flying, Speed_up=1 for 3 ticks -> PosX drops by 24.
REQ-041 Ch0 at PosX=-88, one tick -> ch0 IDLE, same-tick spawn goes to ch1 (gap=0), never to ch0.
REQ-042 Both channels overlap at the pixel -> flyer_id=0, address from ch0, 1 Clk after the pixel.
REQ-043 Dead=1 for 20 ticks -> PosX, wing_dn, gap counter and LFSR unchanged.
REQ-044 Cactus_PosX=300, Cactus_SizeX=40, gap counter=0 -> no spawn on the tick.
